// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 host transmitter state encoding, command bytes and frame parity helper.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, DATA, STOP, ACK, WAIT_IDLE} ps2_tx_state_t;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command byte request handshake and completion pulses of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err_nack;
  logic       err_timeout;
  modport master (output tx_data, tx_valid, input tx_ready, done, err_nack, err_timeout);
  modport slave  (input tx_data, tx_valid, output tx_ready, done, err_nack, err_timeout);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for PS2Clk/PS2Data plus PS2Clk falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_o,
  output logic data_o,
  output logic fall_o
);
  logic [2:0] clk_q;
  logic [1:0] data_q;
  // Reset to the idle-high line level so leaving reset never fakes a falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_q  <= '1;
      data_q <= '1;
    end else begin
      clk_q  <= {clk_q[1:0], ps2_clk_i};
      data_q <= {data_q[0], ps2_data_i};
    end
  assign clk_o  = clk_q[1];
  assign data_o = data_q[1];
  assign fall_o = clk_q[2] & ~clk_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving PS2Clk/PS2Data via open-drain enables.
// Build with PS2_HOST_TX_RETRY_EN to retry a NACKed or timed-out byte once before flagging the error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o,
  output logic         rx_inhibit_o
);
`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [8:0]       frame_q, frame_d;
  logic             oe_q, oe_d, retry_q, retry_d;
  logic             clk_s, data_s, fall, last, tout, nack_hit, fail;
  ps2_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_o     (clk_s),
    .data_o    (data_s),
    .fall_o    (fall)
  );
  assign last     = state_q == INHIBIT && cnt_q == CNT_W'(INHIBIT_CYCLES - 1);
  assign tout     = state_q != IDLE && state_q != INHIBIT && cnt_q == CNT_W'(TIMEOUT_CYCLES);
  assign nack_hit = state_q == ACK && fall && data_s && !tout;
  assign fail     = nack_hit || tout;
  assign bus.tx_ready    = state_q == IDLE;
  assign bus.done        = state_q == WAIT_IDLE && clk_s && data_s && !tout;
  assign bus.err_nack    = nack_hit && (!RETRY || retry_q);
  assign bus.err_timeout = tout && (!RETRY || retry_q);
  assign rx_inhibit_o    = state_q != IDLE;
  assign ps2_clk_oe_o    = state_q == INHIBIT;
  assign ps2_data_oe_o   = !tout && (oe_q || last);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    oe_d    = oe_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        frame_d = {odd_parity(bus.tx_data), bus.tx_data};
        retry_d = 1'b0;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        idx_d = '0;
        if (last) begin
          oe_d    = 1'b1;
          state_d = START;
        end
      end
      START, DATA: if (fall) begin
        oe_d    = ~frame_q[idx_q];
        idx_d   = idx_q + 4'd1;
        state_d = idx_q == 4'd8 ? STOP : DATA;
      end
      STOP: if (fall) begin
        oe_d    = 1'b0;
        state_d = ACK;
      end
      ACK:       if (fall) state_d = WAIT_IDLE;
      WAIT_IDLE: if (clk_s && data_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (fail) begin
      oe_d    = 1'b0;
      retry_d = 1'b1;
      state_d = RETRY && !retry_q ? INHIBIT : IDLE;
    end
    // Our own clk pull-down shows up as a fall during INHIBIT; it must not restart the hold count
    cnt_d = state_d != state_q || state_q == IDLE || (fall && state_q != INHIBIT) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      oe_q    <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      oe_q    <= oe_d;
      retry_q <= retry_d;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 5000;
  localparam int TO  = 3000;
  localparam int M_ACK = 0, M_NACK = 1, M_STALL = 2, M_RST = 3;
  localparam int K_DONE = 0, K_NACK = 1, K_TOUT = 2;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif
  typedef struct {
    logic [7:0] b;
    int         kind;
    int         att0;
    int         ov0;
  } exp_t;
  exp_t q[$];
  logic clk = 1'b0, rst_n = 1'b0, dev_clk = 1'b1, dev_data = 1'b1;
  logic clk_oe, data_oe, inhibit, pin_clk, pin_data;
  logic [10:0] obs = '0;
  int total = 0, bad = 0, comp_n = 0, tgt = 0, cyc = 0, attempts = 0, fall_n = 0, t4 = 0;
  int run = 0, inh_last = 0, ov = 0, mode = M_ACK;
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ps2_clk_i    (pin_clk),
    .ps2_data_i   (pin_data),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe),
    .rx_inhibit_o (inhibit)
  );
  assign pin_clk  = ~clk_oe & dev_clk;
  assign pin_data = ~data_oe & dev_data;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask
  // Expected line levels seen by the device: start, 8 data LSB first, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clk_oe) run <= run + 1;
    else if (run != 0) begin
      inh_last <= run;
      run <= 0;
    end
    if (clk_oe && data_oe) ov <= ov + 1;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Device: waits for a host request, clocks 11 bits, samples host data, drives the ack bit
  initial begin
    int h;
    forever begin
      wait (clk_oe);
      wait (!clk_oe);
      @(negedge clk);
      obs[0] = pin_data;
      attempts++;
      h = $urandom_range(12, 30);
      tick(10);
      for (int k = 1; k <= 11; k++) begin
        dev_clk = 1'b0;
        fall_n++;
        if (k == 4) t4 = cyc;
        tick(h);
        if ((mode == M_STALL && k == 4) || (mode == M_RST && k == 5)) begin
          dev_clk = 1'b1;
          break;
        end
        if (k <= 10) obs[k] = pin_data;
        dev_clk = 1'b1;
        if (k == 10) dev_data = (mode == M_NACK);
        tick(h);
      end
      dev_data = 1'b1;
    end
  end
  initial begin
    exp_t e;
    int na;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.done || bus.err_nack || bus.err_timeout)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=%0b required=000", {bus.err_timeout, bus.err_nack, bus.done});
        end else begin
          e  = q.pop_front();
          na = e.kind == K_DONE ? 1 : TRIES;
          chk("pulse_kind", int'({bus.err_timeout, bus.err_nack, bus.done}), 1 << e.kind);
          chk("oe_release", int'({clk_oe, data_oe}), 0);
          chk("attempts", attempts - e.att0, na);
          chk("start_overlap", ov - e.ov0, na);
          chk("inhibit_len", inh_last, INH);
          if (e.kind != K_TOUT) chk("frame", int'(obs), int'(frame_of(e.b)));
          else chk("tout_delay", int'(cyc - t4 >= TO && cyc - t4 <= TO + 8), 1);
          if (e.kind == K_DONE) begin
            chk("ready_at_done", int'(bus.tx_ready), 0);
            @(negedge clk);
            chk("ready_after_done", int'(bus.tx_ready), 1);
          end
          comp_n++;
        end
      end
    end
  end
  task automatic pulse_valid(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int m, input int k, input bit busy);
    exp_t e;
    int f0;
    mode   = m;
    e.b    = b;
    e.kind = k;
    e.att0 = attempts;
    e.ov0  = ov;
    q.push_back(e);
    tgt++;
    f0 = fall_n;
    pulse_valid(b);
    if (busy) begin
      for (int i = 0; i < 20000 && fall_n < f0 + 3; i++) @(negedge clk);
      pulse_valid(8'h00);
    end
    for (int i = 0; i < 30000 && comp_n < tgt; i++) @(negedge clk);
    chk("complete", comp_n, tgt);
    repeat (20) @(negedge clk);
  endtask
  initial begin
    int f0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.tx_ready), 1);
    chk("rst_oe", int'({clk_oe, data_oe}), 0);
    chk("rst_inhibit", int'(inhibit), 0);
    chk("rst_pulses", int'({bus.done, bus.err_nack, bus.err_timeout}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(PS2_CMD_SET_LED, M_ACK, K_DONE, 1'b0);
    send(8'h01, M_ACK, K_DONE, 1'b0);
    send(PS2_CMD_RESET, M_ACK, K_DONE, 1'b0);
    send(8'($urandom), M_NACK, K_NACK, 1'b0);
    send(8'($urandom), M_STALL, K_TOUT, 1'b0);
    mode = M_RST;
    f0 = fall_n;
    pulse_valid(8'h5A);
    for (int i = 0; i < 20000 && fall_n < f0 + 5; i++) @(negedge clk);
    repeat (4) @(posedge clk);
    chk("busy_before_rst", int'(inhibit), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_oe", int'({clk_oe, data_oe}), 0);
    chk("midrst_ready", int'(bus.tx_ready), 1);
    chk("midrst_inhibit", int'(inhibit), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    send(PS2_CMD_ENABLE, M_ACK, K_DONE, 1'b0);
    send(8'hA5, M_ACK, K_DONE, 1'b1);
    repeat (2) send(8'($urandom), M_ACK, K_DONE, 1'b0);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction of the keyboard receiver. Sends command bytes to the keyboard, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- Runs in the keyboard clock domain (50 MHz) and drives PS2Clk/PS2Data through open-drain enables.
- Flags an inhibit window so the receiver ignores line activity while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 5000, clock-low hold before start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max cycles between device clock falling edges, and from inhibit release to first falling edge (15 ms).
- CNT_W, 20, width of the shared cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  50 MHz keyboard clock.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2Clk pin level.
- ps2_data_in  in  1  raw PS2Data pin level.
- ps2_clk_oe  out  1  1 = pull PS2Clk low.
- ps2_data_oe  out  1  1 = pull PS2Data low.
- rx_inhibit  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse: byte sent and ACKed.
- err_nack  out  1  1-cycle pulse: ack bit read as 1.
- err_timeout  out  1  1-cycle pulse: timeout expired.

Behaviour:
- Reset (async, rst=0): state IDLE; all OE outputs 0 (lines released); done/err pulses 0; tx_ready 1; rx_inhibit 0; counters and shift register cleared.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. fall = previous synced clk 1 and current 0. Every falling edge therefore reaches the FSM 3 cycles after the pin edge.
- Acceptance: on acceptance, latch {parity, tx_data}. parity = ~^tx_data (odd parity). Go to INHIBIT; ps2_clk_oe=1 from the next cycle. tx_valid is ignored outside IDLE.
- INHIBIT: hold clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle set data_oe=1 (start bit 0) and go to START.
- START: clk_oe=0 on the first START cycle. data_oe stays 1. Bit index = 0.
- DATA: on each fall, drive bit[idx] with data_oe = ~bit, then idx++. Bits are LSB first; falls 1..8 carry data bits, fall 9 carries parity.
- STOP: fall 10 sets data_oe=0 (stop bit 1). Go to ACK.
- ACK: on fall 11 sample synced data. 0 → WAIT_IDLE; 1 → pulse err_nack, go to IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1, then pulse done and go to IDLE. tx_ready rises the cycle after done.
- Timeout: the counter clears on every fall and on state entry. In START, DATA, STOP, ACK and WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES: release both OEs in the same cycle, pulse err_timeout, go to IDLE.
- done, err_nack and err_timeout are mutually exclusive; at most one pulse per accepted byte, or per final attempt when the optional feature is built in.
- Lines are never driven high; only OE is used. clk_oe and data_oe are never both 1 outside the INHIBIT→START handover.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined: on NACK or timeout, re-enter INHIBIT once with the same latched byte. The error pulse fires only if the second attempt also fails. rx_inhibit stays high across the retry.
- Undefined: no retry; the error pulse fires on the first failure.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, START, DATA, STOP, ACK, WAIT_IDLE);
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4;
  - a parity function.
- One natural sub-module: ps2_line_sync (2-flop sync plus falling-edge detect). It is shareable with the receiver.

Test Plan:
- Send 0xED with a device model that ACKs → data_oe pattern on falls 1..9 = ~{1,0,1,1,0,1,1,1,1}; clk_oe high exactly 5000 cycles; done pulse once; tx_ready back to 1.
- Send 0x01 → parity bit 0, so data_oe=1 on fall 9. Send 0xFF → parity 1. Both end in done.
- Device drives ack=1 on fall 11 → err_nack pulse, no done. With PS2_HOST_TX_RETRY_EN defined, a second INHIBIT phase is observed before err_nack.
- Device stops clocking after fall 4 → after 750000 cycles, err_timeout pulses and both OEs go to 0 in the same cycle.
- rst=0 asserted mid-DATA (after fall 5) → OEs 0 and tx_ready 1 with no clock edge required. A fresh 0xF4 afterwards completes normally.
- tx_valid pulsed with 0x00 while busy → ignored; the original byte completes unchanged.
